// File: rtl/mc_mem_pkg.sv
// rtl/mc_mem_pkg.sv - shared FSM state type and default parameters for mc_wait_mem
package mc_mem_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_DEPTH   = 256;
    localparam int DEF_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mc_mem_array.sv
// rtl/mc_mem_array.sv - word storage with one synchronous write port and one read port
module mc_mem_array
    import mc_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents are deliberately left unreset; only the controller state is reset.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mc_wait_mem.sv
// rtl/mc_wait_mem.sv - fixed-latency wait-state memory controller; MC_MEM_BUSY_CNT_EN enables busy_cnt
module mc_wait_mem
    import mc_mem_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       adrs,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [DATA_W-1:0] rd_data,
    output logic              ready,
    output logic              busy,
    output logic              err,
    output logic [31:0]       busy_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              op_wr_q, op_wr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;

    logic [AW-1:0]     req_idx;
    logic [AW-1:0]     arr_raddr;
    logic [DATA_W-1:0] arr_rdata;
    logic              arr_we;
    logic              unused_adrs;

    // Upper address bits wrap modulo DEPTH and byte offset is ignored.
    assign req_idx     = adrs[AW+1:2];
    assign unused_adrs = ^{adrs[31:AW+2], adrs[1:0]};

    // On a single-cycle latency the read happens straight from IDLE, before idx_q is loaded.
    assign arr_raddr = (state_q == IDLE) ? req_idx : idx_q;

    // Write commits at the edge closing DONE, so a reset during DONE still cancels it.
    assign arr_we = (state_q == DONE) && op_wr_q && !rst;

    mc_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (idx_q),
        .wdata (wdata_q),
        .raddr (arr_raddr),
        .rdata (arr_rdata)
    );

    // Next-state logic: accept in IDLE, count down in BUSY, one-cycle completion in DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        op_wr_d   = op_wr_q;
        rd_data_d = rd_data_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    idx_d   = req_idx;
                    wdata_d = wr_data;
                    op_wr_d = mem_write;
                    cnt_d   = CNT_LOAD;
                    err_d   = mem_read && mem_write;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                        ready_d = 1'b1;
                        if (!mem_write) begin
                            rd_data_d = arr_rdata;
                        end
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CW'(1)) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    if (!op_wr_q) begin
                        rd_data_d = arr_rdata;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            op_wr_q   <= 1'b0;
            rd_data_q <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            op_wr_q   <= op_wr_d;
            rd_data_q <= rd_data_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    assign rd_data = rd_data_q;
    assign ready   = ready_q;
    assign err     = err_q;
    assign busy    = (state_q == BUSY) || (state_q == DONE);

`ifdef MC_MEM_BUSY_CNT_EN
    logic [31:0] busy_cnt_q, busy_cnt_d;

    // Free-running count of BUSY cycles, wrapping naturally at 2^32.
    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (state_q == BUSY) begin
            busy_cnt_d = busy_cnt_q + 32'd1;
        end
    end

    // Busy counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt_q <= '0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;
`else
    assign busy_cnt = '0;
`endif

endmodule

// File: doc/mc_wait_mem.md
MC_WAIT_MEM -- requirements
Module: mc_wait_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, meaning number of words; power of two, at least 2.
REQ-003 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to ready; at least 1.
REQ-004 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 adrs  input  32  byte address from core; word index = adrs[log2(DEPTH)+1:2].
REQ-008 wr_data  input  DATA_W  write data from core.
REQ-009 mem_read  input  1  read request level, held by core until ready.
REQ-010 mem_write  input  1  write request level, held by core until ready.
REQ-011 rd_data  output  DATA_W  read data returned to core.
REQ-012 ready  output  1  one-cycle completion pulse.
REQ-013 busy  output  1  high while a request is in flight (BUSY or DONE).
REQ-014 err  output  1  one-cycle pulse when mem_read and mem_write are both high at acceptance.
REQ-015 busy_cnt  output  32  count of cycles spent in BUSY.

Function
REQ-016 FSM SHALL have states IDLE, BUSY and DONE.
REQ-017 In IDLE, mem_read or mem_write high SHALL latch the word index, wr_data and operation, load wait counter with LATENCY-1, and go to BUSY (or to DONE when LATENCY=1).
REQ-018 In BUSY, the counter SHALL decrement each cycle, and the FSM SHALL go to DONE when the counter is 0.
REQ-019 In DONE, ready SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-020 ready SHALL rise exactly LATENCY cycles after the acceptance edge.
REQ-021 A write SHALL update the array on the DONE cycle edge.
REQ-022 For a read, rd_data SHALL load on the DONE cycle edge, be valid while ready is high, and hold until the next read completes.
REQ-023 Requests SHALL be accepted only in IDLE; the minimum spacing between accepts SHALL be LATENCY+1 cycles.
REQ-024 If a request is deasserted while BUSY, the latched operation SHALL still complete.
REQ-025 If mem_read and mem_write are both high at acceptance, the write SHALL be performed, no read SHALL occur, and err SHALL pulse in the accept cycle.
REQ-026 Address bits outside the word index SHALL be ignored (index wraps modulo DEPTH); byte offset bits [1:0] SHALL be ignored.
REQ-027 busy SHALL be combinationally high in BUSY and DONE.

Reset
REQ-028 Reset SHALL set: state IDLE, counter 0, rd_data 0, ready 0, err 0, busy_cnt 0.
REQ-029 Reset during BUSY or DONE SHALL abort the operation, with no array write and no ready pulse.
REQ-030 Array contents SHALL NOT be reset.

Configuration
REQ-031 Macro MC_MEM_BUSY_CNT_EN defined: busy_cnt SHALL increment by 1 every BUSY cycle and wrap from 2^32-1 to 0.
REQ-032 Macro MC_MEM_BUSY_CNT_EN undefined: busy_cnt SHALL be tied to 0 and no counter register SHALL exist.

Structure
REQ-033 Shared package mc_mem_pkg SHALL hold the FSM state enum (IDLE, BUSY, DONE) and default DATA_W, DEPTH and LATENCY constants.
REQ-034 Storage SHALL be a sub-module mc_mem_array with one synchronous write port and one read port, parametrised by DATA_W and DEPTH.

Verification
REQ-035 LATENCY=2: write 0xDEADBEEF to adrs 0x10 at cycle 0 -> ready at cycle 2; read of 0x10 -> rd_data=0xDEADBEEF with ready 2 cycles after accept.
REQ-036 LATENCY=1 and LATENCY=4: back-to-back reads held high -> ready every 2 and every 5 cycles respectively.
REQ-037 DEPTH=256: write 0x1 to adrs 0x400, read adrs 0x000 -> rd_data=0x1 (wrap-around).
REQ-038 mem_read and mem_write both high with wr_data=0x55 at adrs 0x8 -> err pulses once; subsequent read of 0x8 returns 0x55.
REQ-039 Write accepted, then rst high in BUSY -> no ready pulse, outputs 0, and old word at that address unchanged.
REQ-040 With MC_MEM_BUSY_CNT_EN, LATENCY=3 and 4 accesses -> busy_cnt=8; without the macro -> busy_cnt=0.
